parity_frame_gen: RTL
=====================

# parity_frame_gen

Streaming parity generator that extends the single-word even-parity function to multi-word frames with valid/ready flow control. It attaches a row-parity bit to every `DATA_W`-bit word and appends one trailer beat carrying the longitudinal (column) parity of the frame, with even or odd parity selectable per frame. It sits between a word-oriented data source and a serialiser/link layer that needs row and column parity for error detection.

## Interface
- `DATA_W`, 8: data word width in bits (≥1)
- `CNT_W`, 16: width of the completed-frame counter
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `odd_mode`  in  1  0 = even parity, 1 = odd parity; sampled on the first word of each frame
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  block accepts input word
- `in_data`  in  DATA_W  input word
- `in_last`  in  1  word is last of frame
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  sink accepts output beat
- `out_data`  out  DATA_W  data word, or LRC on trailer beat
- `out_par`  out  1  row parity of `out_data`
- `out_last`  out  1  high only on trailer beat
- `out_trailer`  out  1  high only on trailer beat
- `frame_cnt`  out  CNT_W  number of trailers delivered, wraps modulo 2^CNT_W

## Operation
- Row parity: even mode `out_par = ^word`; odd mode `out_par = ~^word`. Total ones in {word, par} is even/odd respectively.
- LRC accumulator `lrc` (DATA_W): cleared to 0 on reset and after each trailer handshake; on every accepted input word `lrc <= lrc ^ in_data`.
- Trailer `out_data`: even mode = final `lrc`; odd mode = `~lrc`. Trailer `out_par` follows the same row-parity rule applied to the trailer data.
- Frame mode: `odd_mode` latched into `mode_q` on the first accepted word of a frame; changes mid-frame are ignored until the next frame.
- States: `RUN` (accepting words), `TRL_WAIT` (last word accepted, trailer not yet loaded), `TRL_OUT` (trailer held in output register).
- `RUN` -> `TRL_WAIT` on accepting a word with `in_last=1`.
- `TRL_WAIT` -> `TRL_OUT` when the output register is free (`!out_valid || out_ready`); the trailer is loaded in that cycle.
- `TRL_OUT` -> `RUN` on trailer handshake; `frame_cnt` increments in the same cycle.
- `in_ready = (state==RUN) && (!out_valid || out_ready)`, combinational.
- Data beats always have `out_last=0`, `out_trailer=0`; `in_last` is not forwarded.
- Single-word frame: trailer data equals the word (even) or its complement (odd).

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_par=0`, `out_last=0`, `out_trailer=0`, `frame_cnt=0`, `lrc=0`, `mode_q=0`, state `RUN`; `in_ready` is therefore 1 while the output is empty.
- Data latency: a word accepted in cycle N is presented in cycle N+1 (one output register).
- Throughput: one word per cycle inside a frame; a frame of K words uses K+1 output beats. Input is stalled from acceptance of the last word until the trailer handshake, so there is a gap of at least one cycle per frame.
- Output holds stable (`out_data`, `out_par`, `out_last`, `out_trailer`) while `out_valid && !out_ready`.
- Simultaneous output handshake and new input acceptance in the same cycle is allowed (full throughput).
- Reset asserted mid-frame: everything returns to reset values immediately, the partial frame is discarded, and no trailer is produced.
- `frame_cnt` wraps from 2^CNT_W−1 to 0.

## Structure
- Shared package `parity_pkg`: state enum (`RUN`, `TRL_WAIT`, `TRL_OUT`), mode constants `PAR_EVEN=1'b0`/`PAR_ODD=1'b1`, and a function `row_par(word, mode)` parametrised by width.
- No sub-module; a single module with the output register, the LRC accumulator and the 3-state FSM.

## Test plan
- Even, frame {0x01, 0xFF, 0xAA(last)}, `out_ready=1` -> beats (0x01,1), (0xFF,0), (0xAA,0), trailer (0x54,1,last); `frame_cnt`=1.
- Odd, same frame -> beats (0x01,0), (0xFF,1), (0xAA,1), trailer (0xAB,0,last).
- Even single-word frame 0xEC(last) -> (0xEC,1) then trailer (0xEC,1); `in_ready` low from the cycle after acceptance until the trailer handshake.
- Backpressure: `out_ready=0` for 3 cycles during a frame -> output beat held unchanged, `in_ready=0`, no words lost or duplicated, LRC still 0x54.
- Toggle `odd_mode` mid-frame -> the whole frame uses the mode sampled on its first word; the next frame uses the new mode.
- Assert `rst_n` low after 2 words of a frame -> all outputs return to reset values, `frame_cnt=0`; the next frame {0x0F(last)} gives trailer 0x0F with no residue from the aborted frame.

Source files
------------

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types, mode constants and row-parity helper for parity_frame_gen
package parity_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        TRL_WAIT = 2'd1,
        TRL_OUT  = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest word row_par accepts; callers zero-extend, which leaves the XOR unchanged.
    localparam int PAR_MAX_W = 64;

    function automatic logic row_par(input logic [PAR_MAX_W-1:0] word, input logic mode);
        return (^word) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/parity_frame_gen.sv
// rtl/parity_frame_gen.sv - streaming row parity per word plus a column-parity (LRC) trailer per frame
module parity_frame_gen
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_last,
    output logic              out_trailer,
    output logic [CNT_W-1:0]  frame_cnt
);

    state_t            state, state_d;
    logic [DATA_W-1:0] lrc;
    logic              mode_q;
    logic              sof_q;
    logic              out_free;
    logic              in_fire;
    logic              trl_fire;
    logic              cur_mode;
    logic [DATA_W-1:0] trl_data;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == RUN) && out_free;
    assign in_fire  = in_valid && in_ready;
    assign trl_fire = (state == TRL_OUT) && out_valid && out_ready;

    // The first word of a frame must use the live mode input, later words the latched one.
    assign cur_mode = sof_q ? odd_mode : mode_q;
    assign trl_data = (mode_q == PAR_ODD) ? ~lrc : lrc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            RUN:      if (in_fire && in_last) state_d = TRL_WAIT;
            TRL_WAIT: if (out_free)           state_d = TRL_OUT;
            TRL_OUT:  if (trl_fire)           state_d = RUN;
            default:                          state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrc    <= '0;
            mode_q <= PAR_EVEN;
            sof_q  <= 1'b1;
        end else if (in_fire) begin
            lrc   <= lrc ^ in_data;
            sof_q <= 1'b0;
            if (sof_q) begin
                mode_q <= odd_mode;
            end
        end else if (trl_fire) begin
            lrc   <= '0;
            sof_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_par     <= 1'b0;
            out_last    <= 1'b0;
            out_trailer <= 1'b0;
        end else if (in_fire) begin
            out_valid   <= 1'b1;
            out_data    <= in_data;
            out_par     <= row_par(PAR_MAX_W'(in_data), cur_mode);
            out_last    <= 1'b0;
            out_trailer <= 1'b0;
        end else if ((state == TRL_WAIT) && out_free) begin
            out_valid   <= 1'b1;
            out_data    <= trl_data;
            out_par     <= row_par(PAR_MAX_W'(trl_data), mode_q);
            out_last    <= 1'b1;
            out_trailer <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (trl_fire) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule
